// File: rtl/float_adder_arbiter.sv
// rtl/float_adder_arbiter.sv - round-robin scheduler sharing one multi-cycle FloatAdder
// among NREQ requesters, with stale-valid blanking and timeout completion.
module float_adder_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64,
    parameter int BLANK   = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NREQ-1:0]   i_req_valid,
    input  logic [32*NREQ-1:0] i_req_op1,
    input  logic [32*NREQ-1:0] i_req_op2,
    output logic [NREQ-1:0]   o_req_ready,
    output logic [NREQ-1:0]   o_rsp_valid,
    output logic [31:0]       o_rsp_result,
    output logic              o_rsp_error,
    output logic              o_busy,
    output logic [31:0]       o_add_op1,
    output logic [31:0]       o_add_op2,
    output logic              o_add_input_valid,
    input  logic [31:0]       i_add_result,
    input  logic              i_add_result_valid
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_g;
    logic [IW-1:0]   r_last;
    logic [CW-1:0]   r_cnt;
    logic [NREQ-1:0] r_req_ready;
    logic [NREQ-1:0] r_rsp_valid;
    logic [31:0]     r_rsp_result;
    logic            r_rsp_error;
    logic            r_busy;
    logic [31:0]     r_add_op1;
    logic [31:0]     r_add_op2;
    logic            r_add_input_valid;

    logic            w_found;
    logic [IW-1:0]   w_grant_idx;
    logic [IW-1:0]   w_cand;
    logic            w_accept;
    logic            w_timeout;

    // Rotating priority: first pending requester after the last one served.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            w_cand = IW'((int'(r_last) + i) % NREQ);
            if (!w_found && i_req_valid[w_cand]) begin
                w_found     = 1'b1;
                w_grant_idx = w_cand;
            end
        end
    end

    assign w_accept  = (r_cnt >= CW'(BLANK)) && i_add_result_valid;
    assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (w_accept || w_timeout) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A genuine result takes precedence over timeout on the final WAIT cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_g               <= '0;
            r_last            <= IW'(NREQ - 1);
            r_cnt             <= '0;
            r_req_ready       <= '0;
            r_rsp_valid       <= '0;
            r_rsp_result      <= '0;
            r_rsp_error       <= 1'b0;
            r_busy            <= 1'b0;
            r_add_op1         <= '0;
            r_add_op2         <= '0;
            r_add_input_valid <= 1'b0;
        end else begin
            r_req_ready       <= '0;
            r_rsp_valid       <= '0;
            r_add_input_valid <= 1'b0;
            r_busy            <= (w_state_nxt != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_g               <= w_grant_idx;
                        r_add_op1         <= i_req_op1[32*w_grant_idx +: 32];
                        r_add_op2         <= i_req_op2[32*w_grant_idx +: 32];
                        r_req_ready       <= ONE << w_grant_idx;
                        r_add_input_valid <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_cnt <= '0;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_accept) begin
                        r_rsp_result <= i_add_result;
                        r_rsp_error  <= 1'b0;
                        r_rsp_valid  <= ONE << r_g;
                    end else if (w_timeout) begin
                        r_rsp_result <= QNAN;
                        r_rsp_error  <= 1'b1;
                        r_rsp_valid  <= ONE << r_g;
                    end
                end
                S_DONE: begin
                    r_last <= r_g;
                end
                default: ;
            endcase
        end
    end

    assign o_req_ready       = r_req_ready;
    assign o_rsp_valid       = r_rsp_valid;
    assign o_rsp_result      = r_rsp_result;
    assign o_rsp_error       = r_rsp_error;
    assign o_busy            = r_busy;
    assign o_add_op1         = r_add_op1;
    assign o_add_op2         = r_add_op2;
    assign o_add_input_valid = r_add_input_valid;

endmodule

// File: doc/float_adder_arbiter.md
# float_adder_arbiter

Round-robin scheduler that shares one multi-cycle FloatAdder among NREQ requesters. It accepts one operand pair at a time, drives the adder's operand and InputValid pins, and waits for ResultValid while blanking stale assertions. It returns the IEEE-754 single-precision sum to the granted requester, and returns a timeout error if the adder never completes. It sits between the requester-side compute units and the single FloatAdder instance.

## Interface

Parameters:
- NREQ, 4: number of requesters (2..8).
- TIMEOUT, 64: max WAIT cycles before error completion (≥ BLANK+1).
- BLANK, 2: WAIT cycles during which AddResultValid is ignored.

Ports:
- Clock  in  1  single clock; all state on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- ReqValid  in  NREQ  request i has an operand pair pending.
- ReqOp1  in  32*NREQ  float operand 1; requester i at [32i+31:32i].
- ReqOp2  in  32*NREQ  float operand 2; same packing.
- ReqReady  out  NREQ  one-hot, one-cycle accept pulse.
- RspValid  out  NREQ  one-hot, one-cycle result pulse to the owning requester.
- RspResult  out  32  sum; meaningful only while any RspValid is high.
- RspError  out  1  high with RspValid when completion was a timeout.
- Busy  out  1  high in every state except IDLE.
- AddOp1, AddOp2  out  32 each  registered operands to FloatAdder Op1/Op2.
- AddInputValid  out  1  one-cycle pulse to FloatAdder InputValid.
- AddResult  in  32  FloatAdder Result.
- AddResultValid  in  1  FloatAdder ResultValid.

## Operation

- FSM states: IDLE, ISSUE, WAIT, DONE.
- The FSM holds an owner register `g`, a last-served pointer `Last`, and a WAIT counter `Cnt` of width clog2(TIMEOUT+1).
- IDLE:
  - ReqValid is sampled only in this state.
  - If any bit is set, grant the first set bit searching from Last+1 upward, modulo NREQ.
  - On that edge, latch the granted operands into AddOp1/AddOp2, set `g`, and go to ISSUE.
  - If no bit is set, stay in IDLE.
- ISSUE, exactly one cycle:
  - AddInputValid=1 and ReqReady[g]=1.
  - Clear Cnt to 0, then go to WAIT.
- WAIT:
  - Cnt increments every cycle.
  - While Cnt<BLANK, ignore AddResultValid.
  - When Cnt≥BLANK and AddResultValid=1: register AddResult into RspResult, set RspError=0, go to DONE.
  - Else, when Cnt==TIMEOUT-1: set RspResult=32'h7FC00000 (qNaN) and RspError=1, go to DONE.
- DONE, exactly one cycle:
  - RspValid[g]=1.
  - Set Last←g, then go to IDLE.
- AddOp1/AddOp2 hold their value from grant until the next grant. They are never changed during WAIT.
- Requester contract: ReqValid and its operands are held until ReqReady is seen. Deasserting ReqValid while in IDLE simply removes the request. The arbiter ignores ReqValid outside IDLE.
- Only one transaction is ever outstanding. No other requester is granted until DONE completes.

## Timing

- Reset values (asynchronous, Reset=0): state=IDLE, Last=NREQ-1 (requester 0 has first priority), g=0, Cnt=0, all outputs 0 (ReqReady, RspValid, RspResult, RspError, Busy, AddOp1, AddOp2, AddInputValid).
- All outputs are registered.
- Grant timing: a request sampled in IDLE at edge t gives ReqReady and AddInputValid high in cycle t+1.
- WAIT starts at t+2.
- If AddResultValid is first accepted at WAIT cycle Cnt=k (k≥BLANK), RspValid is high in the following cycle.
- Round trip with k = adder latency: 3+k cycles, plus 1 IDLE cycle before the next grant.
- Timeout: RspValid follows TIMEOUT WAIT cycles after ISSUE.
- AddResultValid=1 in the same cycle as Cnt==TIMEOUT-1 (and Cnt≥BLANK): the valid result wins and RspError=0.
- Simultaneous requests: exactly one grant per IDLE visit. Back-to-back requesters are served in strict rotation.
- A continuously asserting requester waits at most NREQ-1 transactions.
- Reset asserted mid-transaction: the transaction is dropped immediately. No RspValid or ReqReady is emitted afterwards, and after reset release the FSM is in IDLE.
- Busy is 0 only in IDLE.

## Test plan

- Single requester: ReqValid[0]=1, Op1=3F800000 (1.0), Op2=40000000 (2.0), adder model completes after 5 cycles. Required: ReqReady[0] for one cycle, then RspValid[0] for one cycle with RspResult=40400000 and RspError=0; Busy drops after.
- All four requesters asserted from reset with distinct operand pairs. Required: grants in order 0,1,2,3, then 0 again; each RspValid is one-hot and matches its requester's sum; AddInputValid is never high while Busy was already high from the prior transaction.
- Stale valid: adder model holds AddResultValid=1 through ISSUE and the first two WAIT cycles, then drops it and asserts the real result at Cnt=4. Required: the response carries the value present at Cnt=4, not the stale value.
- Timeout: the adder never asserts AddResultValid. Required: RspValid[g] and RspError=1 with RspResult=7FC00000 exactly 64 WAIT cycles after ISSUE; the next pending request is then granted normally.
- Result and timeout collide: AddResultValid is asserted first at Cnt=63 with result 41200000. Required: RspResult=41200000 and RspError=0.
- Reset mid-WAIT: Reset pulled low at Cnt=3. Required: all outputs are 0 immediately; after release there is no RspValid for the dropped transaction and requester 0 is granted first on a new request.
